// File: rtl/field_sel_cu_if.sv
// Input events (debounced buttons, UART bytes) and registered selection outputs
// of the field-select control unit.
interface field_sel_cu_if #(
    parameter int NUM_FIELDS = 4,
    parameter int PAGE_SIZE  = 2
);
    localparam int NUM_PAGES = NUM_FIELDS / PAGE_SIZE;
    localparam int SEL_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

    logic              btn_left;
    logic              btn_right;
    logic              btn_page;
    logic              btn_edit;
    logic              btn_up;
    logic              btn_down;
    logic [7:0]        uart_rx;
    logic              uart_rx_done;

    logic [SEL_W-1:0]  o_field_sel;
    logic [PAGE_W-1:0] o_page;
    logic              o_edit;
    logic              o_inc;
    logic              o_dec;
    logic              o_blink;

    modport master (
        output btn_left, btn_right, btn_page, btn_edit, btn_up, btn_down,
        output uart_rx, uart_rx_done,
        input  o_field_sel, o_page, o_edit, o_inc, o_dec, o_blink
    );

    modport slave (
        input  btn_left, btn_right, btn_page, btn_edit, btn_up, btn_down,
        input  uart_rx, uart_rx_done,
        output o_field_sel, o_page, o_edit, o_inc, o_dec, o_blink
    );
endinterface

// File: rtl/field_sel_cu.sv
// Paged field-select control unit with an EDIT mode that issues inc/dec pulses,
// drives a blink phase and falls back to IDLE after a period of inactivity.
module field_sel_cu #(
    parameter int NUM_FIELDS   = 4,
    parameter int PAGE_SIZE    = 2,
    parameter int WRAP         = 0,
    parameter int IDLE_TIMEOUT = 500_000_000,
    parameter int BLINK_HALF   = 50_000_000
) (
    input logic           clk,
    input logic           rst,
    field_sel_cu_if.slave bus
);
    localparam int NUM_PAGES = NUM_FIELDS / PAGE_SIZE;
    localparam int SEL_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int POS_W     = (PAGE_SIZE > 1) ? $clog2(PAGE_SIZE) : 1;
    localparam int IDLE_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam int BLINK_W   = $clog2(BLINK_HALF + 1);

    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(PAGE_SIZE - 1);
    localparam logic [PAGE_W-1:0]  PAGE_LAST  = PAGE_W'(NUM_PAGES - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    if (PAGE_SIZE < 1 || (NUM_FIELDS % PAGE_SIZE) != 0) begin : g_bad_layout
        $error("field_sel_cu: NUM_FIELDS must be a positive multiple of PAGE_SIZE");
    end
    if (IDLE_TIMEOUT < 1 || BLINK_HALF < 1) begin : g_bad_timing
        $error("field_sel_cu: IDLE_TIMEOUT and BLINK_HALF must be at least 1");
    end

    typedef enum logic {ST_IDLE, ST_EDIT} state_t;

    typedef enum logic [2:0] {
        EV_NONE, EV_NEXT, EV_PREV, EV_EDIT, EV_LEFT, EV_RIGHT, EV_UP, EV_DOWN
    } event_t;

    function automatic event_t uart_event(input logic [7:0] b);
        case (b)
            8'h4C, 8'h6C: return EV_LEFT;
            8'h52, 8'h72: return EV_RIGHT;
            8'h4E, 8'h6E: return EV_NEXT;
            8'h50, 8'h70: return EV_PREV;
            8'h45, 8'h65: return EV_EDIT;
            8'h55, 8'h75: return EV_UP;
            8'h44, 8'h64: return EV_DOWN;
            default:      return EV_NONE;
        endcase
    endfunction

    state_t             state_q,     state_d;
    logic [POS_W-1:0]   pos_q,       pos_d;
    logic [PAGE_W-1:0]  page_q,      page_d;
    logic [SEL_W-1:0]   field_sel_q, field_sel_d;
    logic [IDLE_W-1:0]  idle_cnt_q,  idle_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q,     blink_d;
    logic               inc_q,       inc_d;
    logic               dec_q,       dec_d;
    event_t             evt;

    // One event per cycle: any button beats UART, then fixed button priority.
    always_comb begin
        evt = EV_NONE;
        if      (bus.btn_page)     evt = EV_NEXT;
        else if (bus.btn_edit)     evt = EV_EDIT;
        else if (bus.btn_left)     evt = EV_LEFT;
        else if (bus.btn_right)    evt = EV_RIGHT;
        else if (bus.btn_up)       evt = EV_UP;
        else if (bus.btn_down)     evt = EV_DOWN;
        else if (bus.uart_rx_done) evt = uart_event(bus.uart_rx);
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves
        // one unassigned and no latch is inferred.
        state_d     = state_q;
        pos_d       = pos_q;
        page_d      = page_q;
        idle_cnt_d  = idle_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        inc_d       = 1'b0;
        dec_d       = 1'b0;

        case (evt)
            EV_LEFT: begin
                if (pos_q != POS_LAST)  pos_d = pos_q + 1'b1;
                else if (WRAP != 0)     pos_d = '0;
            end
            EV_RIGHT: begin
                if (pos_q != '0)        pos_d = pos_q - 1'b1;
                else if (WRAP != 0)     pos_d = POS_LAST;
            end
            EV_NEXT: page_d = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
            EV_PREV: page_d = (page_q == '0) ? PAGE_LAST : page_q - 1'b1;
            default: ;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (evt == EV_EDIT) begin
                    state_d     = ST_EDIT;
                    idle_cnt_d  = '0;
                    blink_cnt_d = '0;
                    blink_d     = 1'b1;
                end
            end
            ST_EDIT: begin
                if (evt == EV_EDIT) begin
                    state_d     = ST_IDLE;
                    idle_cnt_d  = '0;
                    blink_cnt_d = '0;
                    blink_d     = 1'b0;
                end else begin
                    inc_d = (evt == EV_UP);
                    dec_d = (evt == EV_DOWN);
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                    // An accepted event always outranks a coincident timeout.
                    if (evt != EV_NONE) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        state_d     = ST_IDLE;
                        idle_cnt_d  = '0;
                        blink_cnt_d = '0;
                        blink_d     = 1'b0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
        endcase

        field_sel_d = SEL_W'(int'(page_d) * PAGE_SIZE + int'(pos_d));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pos_q       <= '0;
            page_q      <= '0;
            field_sel_q <= '0;
            idle_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            page_q      <= page_d;
            field_sel_q <= field_sel_d;
            idle_cnt_q  <= idle_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
        end
    end

    assign bus.o_field_sel = field_sel_q;
    assign bus.o_page      = page_q;
    assign bus.o_edit      = (state_q == ST_EDIT);
    assign bus.o_inc       = inc_q;
    assign bus.o_dec       = dec_q;
    assign bus.o_blink     = blink_q;
endmodule

// File: tb/tb_field_sel_cu.sv
// Bench for field_sel_cu: a saturating and a wrapping instance see the same
// stimulus and are compared against a field-index reference model.
module tb_field_sel_cu;
    localparam int NF = 6;
    localparam int PS = 2;
    localparam int T  = 20;
    localparam int BH = 4;

    localparam int B_PAGE  = 0;
    localparam int B_EDIT  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_UP    = 4;
    localparam int B_DOWN  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    field_sel_cu_if #(.NUM_FIELDS(NF), .PAGE_SIZE(PS)) bus0 ();
    field_sel_cu_if #(.NUM_FIELDS(NF), .PAGE_SIZE(PS)) bus1 ();

    field_sel_cu #(.NUM_FIELDS(NF), .PAGE_SIZE(PS), .WRAP(0),
                   .IDLE_TIMEOUT(T), .BLINK_HALF(BH)) dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    field_sel_cu #(.NUM_FIELDS(NF), .PAGE_SIZE(PS), .WRAP(1),
                   .IDLE_TIMEOUT(T), .BLINK_HALF(BH)) dut_w (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct packed {
        logic       page, edit, left, right, up, down, rx_done;
        logic [7:0] rx;
    } stim_t;

    // Model state: absolute field index, cycles since EDIT entry, quiet cycles.
    typedef struct {
        int field;
        bit edit;
        int quiet;
        int age;
        bit inc;
        bit dec;
    } model_t;

    model_t     m [2];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] cmd_tbl [0:15] = '{8'h4C, 8'h6C, 8'h52, 8'h72, 8'h4E, 8'h6E, 8'h50, 8'h70,
                                   8'h45, 8'h65, 8'h55, 8'h75, 8'h44, 8'h64, 8'h41, 8'h00};

    function automatic stim_t btn(int idx);
        stim_t s = '0;
        case (idx)
            B_PAGE:  s.page  = 1'b1;
            B_EDIT:  s.edit  = 1'b1;
            B_LEFT:  s.left  = 1'b1;
            B_RIGHT: s.right = 1'b1;
            B_UP:    s.up    = 1'b1;
            default: s.down  = 1'b1;
        endcase
        return s;
    endfunction

    function automatic stim_t uart(logic [7:0] b);
        stim_t s = '0;
        s.rx_done = 1'b1;
        s.rx      = b;
        return s;
    endfunction

    // 0 none, 1 next, 2 prev, 3 edit, 4 left, 5 right, 6 up, 7 down
    function automatic int model_event(stim_t s);
        if (s.page)  return 1;
        if (s.edit)  return 3;
        if (s.left)  return 4;
        if (s.right) return 5;
        if (s.up)    return 6;
        if (s.down)  return 7;
        if (!s.rx_done) return 0;
        case (s.rx | 8'h20)
            8'h6E:   return 1;
            8'h70:   return 2;
            8'h65:   return 3;
            8'h6C:   return 4;
            8'h72:   return 5;
            8'h75:   return 6;
            8'h64:   return 7;
            default: return 0;
        endcase
    endfunction

    function automatic void model_step(int d, stim_t s);
        int ev  = model_event(s);
        int pos = m[d].field % PS;
        m[d].inc = 0;
        m[d].dec = 0;
        case (ev)
            1: m[d].field = (m[d].field + PS) % NF;
            2: m[d].field = (m[d].field + NF - PS) % NF;
            4: if (pos < PS - 1) m[d].field++; else if (d == 1) m[d].field -= PS - 1;
            5: if (pos > 0) m[d].field--; else if (d == 1) m[d].field += PS - 1;
            default: ;
        endcase
        if (!m[d].edit) begin
            if (ev == 3) begin
                m[d].edit  = 1;
                m[d].quiet = 0;
                m[d].age   = 0;
            end
        end else if (ev == 3) begin
            m[d].edit = 0;
        end else begin
            m[d].age++;
            m[d].inc = (ev == 6);
            m[d].dec = (ev == 7);
            if (ev != 0) m[d].quiet = 0;
            else begin
                m[d].quiet++;
                if (m[d].quiet == T) m[d].edit = 0;
            end
        end
    endfunction

    function automatic logic [7:0] mdl_out(int d);
        bit blink = m[d].edit && ((m[d].age / BH) % 2 == 0);
        return {3'(m[d].field), 2'(m[d].field / PS), m[d].edit, m[d].inc, m[d].dec, blink};
    endfunction

    function automatic logic [7:0] dut_out(int d);
        if (d == 0)
            return {bus0.o_field_sel, bus0.o_page, bus0.o_edit, bus0.o_inc, bus0.o_dec, bus0.o_blink};
        return {bus1.o_field_sel, bus1.o_page, bus1.o_edit, bus1.o_inc, bus1.o_dec, bus1.o_blink};
    endfunction

    task automatic apply(input stim_t s);
        bus0.btn_page = s.page;  bus1.btn_page = s.page;
        bus0.btn_edit = s.edit;  bus1.btn_edit = s.edit;
        bus0.btn_left = s.left;  bus1.btn_left = s.left;
        bus0.btn_right = s.right; bus1.btn_right = s.right;
        bus0.btn_up = s.up;      bus1.btn_up = s.up;
        bus0.btn_down = s.down;  bus1.btn_down = s.down;
        bus0.uart_rx_done = s.rx_done; bus1.uart_rx_done = s.rx_done;
        bus0.uart_rx = s.rx;     bus1.uart_rx = s.rx;
    endtask

    // Drive one input cycle, advance the model, and return 1 time unit after the edge.
    task automatic step(input stim_t s);
        @(negedge clk);
        apply(s);
        model_step(0, s);
        model_step(1, s);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply('0);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) m[d] = '{0, 0, 0, 0, 0, 0};
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply('0);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) m[d] = '{0, 0, 0, 0, 0, 0};
        #12;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (dut_out(d) !== 8'h00) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %b expected 00000000", d, dut_out(d));
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_position();
        stim_t seq [6];
        int    exp_field [6] = '{1, 1, 1, 0, 0, 0};
        do_reset();
        seq = '{btn(B_LEFT), btn(B_LEFT), btn(B_LEFT), btn(B_RIGHT), btn(B_RIGHT), btn(B_RIGHT)};
        for (int i = 0; i < 6; i++) begin
            step(seq[i]);
            n_checks++;
            if (bus0.o_field_sel !== 3'(exp_field[i])) begin
                n_fail++;
                $display("FAIL saturate[%0d]: field got %0d expected %0d", i, bus0.o_field_sel, exp_field[i]);
            end
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (dut_out(d) !== mdl_out(d)) begin
                    n_fail++;
                    $display("FAIL position[%0d] dut%0d: got %b expected %b", i, d, dut_out(d), mdl_out(d));
                end
            end
        end
    endtask

    task automatic test_pages();
        stim_t seq [6];
        int    exp_field [6] = '{1, 3, 5, 1, 5, 5};
        int    exp_page  [6] = '{0, 1, 2, 0, 2, 2};
        do_reset();
        seq = '{btn(B_LEFT), uart(8'h6E), uart(8'h6E), uart(8'h6E), uart(8'h50), uart(8'h41)};
        for (int i = 0; i < 6; i++) begin
            step(seq[i]);
            n_checks++;
            if (bus0.o_field_sel !== 3'(exp_field[i]) || bus0.o_page !== 2'(exp_page[i])) begin
                n_fail++;
                $display("FAIL page[%0d]: field/page got %0d/%0d expected %0d/%0d",
                         i, bus0.o_field_sel, bus0.o_page, exp_field[i], exp_page[i]);
            end
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (dut_out(d) !== mdl_out(d)) begin
                    n_fail++;
                    $display("FAIL pages[%0d] dut%0d: got %b expected %b", i, d, dut_out(d), mdl_out(d));
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(btn(B_LEFT));
        step(btn(B_LEFT));
        n_checks++;
        if (bus1.o_field_sel !== 3'd0 || bus0.o_field_sel !== 3'd1) begin
            n_fail++;
            $display("FAIL wrap_left: wrap/sat field got %0d/%0d expected 0/1", bus1.o_field_sel, bus0.o_field_sel);
        end
        step(uart(8'h72));
        n_checks++;
        if (bus1.o_field_sel !== 3'd1 || bus0.o_field_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_right: wrap/sat field got %0d/%0d expected 1/0", bus1.o_field_sel, bus0.o_field_sel);
        end
    endtask

    task automatic test_edit();
        do_reset();
        step(btn(B_UP));
        n_checks++;
        if (bus0.o_inc !== 1'b0 || bus0.o_edit !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_up: inc/edit got %b/%b expected 0/0", bus0.o_inc, bus0.o_edit);
        end
        step(uart(8'h45));
        n_checks++;
        if (bus0.o_edit !== 1'b1 || bus0.o_blink !== 1'b1) begin
            n_fail++;
            $display("FAIL edit_entry: edit/blink got %b/%b expected 1/1", bus0.o_edit, bus0.o_blink);
        end
        for (int k = 1; k <= 8; k++) begin
            step('0);
            n_checks++;
            if (bus0.o_blink !== ((k / 4) % 2 == 0)) begin
                n_fail++;
                $display("FAIL blink[%0d]: got %b expected %b", k, bus0.o_blink, (k / 4) % 2 == 0);
            end
        end
        step(btn(B_UP));
        n_checks++;
        if (bus0.o_inc !== 1'b1 || bus0.o_dec !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_pulse: inc/dec got %b/%b expected 1/0", bus0.o_inc, bus0.o_dec);
        end
        step(uart(8'h64));
        n_checks++;
        if (bus0.o_inc !== 1'b0 || bus0.o_dec !== 1'b1) begin
            n_fail++;
            $display("FAIL dec_pulse: inc/dec got %b/%b expected 0/1", bus0.o_inc, bus0.o_dec);
        end
        step('0);
        step(uart(8'h65));
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (dut_out(d) !== mdl_out(d)) begin
                n_fail++;
                $display("FAIL edit_exit dut%0d: got %b expected %b", d, dut_out(d), mdl_out(d));
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        step(btn(B_EDIT));
        for (int k = 1; k <= T; k++) begin
            step('0);
            n_checks++;
            if (bus0.o_edit !== (k < T) || (k == T && bus0.o_blink !== 1'b0)) begin
                n_fail++;
                $display("FAIL timeout[%0d]: edit/blink got %b/%b expected %b/0", k, bus0.o_edit, bus0.o_blink, k < T);
            end
        end
        step(btn(B_EDIT));
        for (int k = 1; k < T - 1; k++) step('0);
        step(btn(B_LEFT));
        for (int k = 1; k <= T; k++) begin
            step('0);
            n_checks++;
            if (bus0.o_edit !== (k < T)) begin
                n_fail++;
                $display("FAIL restart[%0d]: edit got %b expected %b", k, bus0.o_edit, k < T);
            end
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        step(btn(B_LEFT));
        step(btn(B_RIGHT) | uart(8'h4C));
        n_checks++;
        if (bus0.o_field_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL btn_beats_uart: field got %0d expected 0", bus0.o_field_sel);
        end
        step(btn(B_PAGE) | btn(B_EDIT));
        n_checks++;
        if (bus0.o_page !== 2'd1 || bus0.o_edit !== 1'b0) begin
            n_fail++;
            $display("FAIL page_beats_edit: page/edit got %0d/%b expected 1/0", bus0.o_page, bus0.o_edit);
        end
        step(btn(B_EDIT) | btn(B_LEFT) | btn(B_UP));
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (dut_out(d) !== mdl_out(d)) begin
                n_fail++;
                $display("FAIL edit_beats_left dut%0d: got %b expected %b", d, dut_out(d), mdl_out(d));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(uart(8'h65));
        step(btn(B_LEFT));
        step(btn(B_UP));
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (dut_out(d) !== 8'h00) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got %b expected 00000000", d, dut_out(d));
            end
        end
        for (int d = 0; d < 2; d++) m[d] = '{0, 0, 0, 0, 0, 0};
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(k == 1 ? btn(B_UP) : stim_t'('0));
            n_checks++;
            if (bus0.o_inc !== 1'b0 || dut_out(0) !== mdl_out(0)) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got %b expected %b", k, dut_out(0), mdl_out(0));
            end
        end
    endtask

    task automatic test_random();
        stim_t s;
        int    pct;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            pct = (i < 400) ? 4 : 1;
            s = '0;
            s.page  = ($urandom_range(99, 0) < pct);
            s.edit  = ($urandom_range(99, 0) < pct);
            s.left  = ($urandom_range(99, 0) < pct);
            s.right = ($urandom_range(99, 0) < pct);
            s.up    = ($urandom_range(99, 0) < pct * 2);
            s.down  = ($urandom_range(99, 0) < pct * 2);
            s.rx_done = ($urandom_range(99, 0) < pct * 3);
            s.rx = cmd_tbl[$urandom_range(15, 0)];
            step(s);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (dut_out(d) !== mdl_out(d) || (dut_out(d) & 8'h06) == 8'h06) begin
                    n_fail++;
                    $display("FAIL random[%0d] dut%0d: got %b expected %b", i, d, dut_out(d), mdl_out(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_position();
        test_pages();
        test_wrap();
        test_edit();
        test_timeout();
        test_arbitration();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
